uart_rx_frame_seq: RTL and testbench
====================================

Name: uart_rx_frame_seq

Overview:
Parametrised receive-frame sequencer for the UART RX path.
- Combines the bit-time tick counter, the bit counter and the frame-format decode into one block.
- Adds runtime-selectable data width (5..MAX_DATA_BITS), optional parity, 1 or 2 stop bits, false-start rejection, an LSB-first data shift register and framing-error reporting.
- Sits between the RX input synchroniser and the RX FIFO/status register.

Parameters:
MAX_DATA_BITS, 9, largest supported data width (5..9)
BAUD_W, 16, width of the bit-time divisor

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx  in  1  synchronised serial input, idle high
baud_div  in  BAUD_W  clock cycles per bit
data_bits  in  4  data bits per frame (5..MAX_DATA_BITS)
p_en  in  1  parity bit present
p_odd  in  1  odd parity select (used only with the optional feature)
stop2  in  1  two stop bits
busy  out  1  frame in progress (state != IDLE)
sample  out  1  one-cycle strobe at mid-bit
bit_idx  out  4  index of the current data bit
data  out  MAX_DATA_BITS  received data, LSB-first, right-justified
done  out  1  one-cycle pulse, frame complete; data valid this cycle
start_err  out  1  one-cycle pulse, false start rejected
frame_err  out  1  one-cycle pulse with done when a stop bit read 0
parity_err  out  1  one-cycle pulse with done on parity mismatch

Behaviour:
- Reset, or any cycle with rst=1, regardless of state:
  - state=IDLE, tick=0, bit_idx=0, data=0.
  - All pulse outputs 0; busy=0.
- Config latch: baud_div, data_bits, p_en, p_odd and stop2 are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Clamping, applied at latch:
  - data_bits<5 -> 5; data_bits>MAX_DATA_BITS -> MAX_DATA_BITS.
  - baud_div<2 -> 2.
- Tick counter:
  - Counts 0..baud_div-1 and wraps to 0.
  - sample=1 when tick==baud_div>>1. bit_end when tick==baud_div-1.
  - Cleared to 0 on every state entry.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: rx==0 -> START.
  - START:
    - On sample with rx==1: start_err=1, -> IDLE.
    - On bit_end: -> DATA, bit_idx=0.
  - DATA:
    - On sample: data shifts right, rx enters at bit (latched data_bits-1), so the result is LSB-first and right-justified.
    - On bit_end: if bit_idx==data_bits-1, go to PARITY if p_en, else STOP1. Otherwise bit_idx+1.
  - PARITY: captures rx on sample; -> STOP1 on bit_end.
  - STOP1, with stop2=0:
    - On sample: done=1, frame_err=~rx, -> IDLE directly, with no wait for bit_end, so the block resyncs to back-to-back frames.
  - STOP1, with stop2=1:
    - On sample: if rx==0, frame_err is recorded.
    - On bit_end: -> STOP2.
  - STOP2:
    - On sample: done=1, frame_err=(recorded STOP1 error | ~rx), -> IDLE.
- On done, upper unused data bits (above data_bits-1) are 0.
- Latency with baud_div=N: done is asserted at cycle (1+data_bits+p_en+stop2)*N + (N>>1) + 1 after the rx-low detection edge.
- Simultaneous events:
  - rx low in the same cycle done fires: ignored. The next start is detected from the following cycle in IDLE.
  - start_err and done are never co-asserted.
- bit_idx holds its value outside DATA and returns to 0 in IDLE.

Optional Feature:
UART_RX_PARITY_CHK_EN
- Defined: on done with latched p_en=1, parity_err = (XOR of data bits ^ parity bit) != p_odd.
- Not defined:
  - parity_err is tied 0 and p_odd is unused.
  - The parity bit is still consumed for timing, but not checked.

Decomposition:
- Shared package uart_pkg holds:
  - The state enum (IDLE..STOP2).
  - MIN_DATA_BITS=5.
  - Frame-length helper constant/function: 1+data_bits+p_en+1+stop2.
- One natural sub-module: uart_bit_tick, which takes the tick counter, clear and baud_div, and outputs sample and bit_end.

Test Plan:
1. 8N1, baud_div=16, byte 0x A5 sent LSB-first -> 10 sample pulses, each at tick 8. done once with data=0x0A5, frame_err=0, parity_err=0. done at cycle 153.
2. Glitch: rx low for 4 cycles, then high, baud_div=16 -> start_err pulse at the START sample, busy drops next cycle, no done.
3. 7E1, 0x41 with a correct even parity bit, then the same frame with parity flipped (feature on) -> parity_err=0, then parity_err=1, each pulsed with done. With the feature off, parity_err is 0 in both cases.
4. 8N2, 0x3C, with the first stop bit forced 0 -> done at the STOP2 sample, frame_err=1, data=0x3C.
5. data_bits=3, baud_div=1 -> clamped to 5 data bits and divisor 2. A 5-bit 0x15 frame yields data=0x015 and done.
6. rst asserted mid-DATA for 1 cycle -> next cycle busy=0, data=0, bit_idx=0, no pulses. The next clean 8N1 frame (0xFF) decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// States, minimum data width and the frame-length helper.
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop1,
      StStop2
   } rx_state_e;

   localparam int unsigned MIN_DATA_BITS = 5;

   // Total bit times in a frame: start + data + parity + stop(s).
   function automatic int unsigned frame_bits(input int unsigned data_bits,
                                              input logic p_en,
                                              input logic stop2);
      return 1 + data_bits + 32'(p_en) + 1 + 32'(stop2);
   endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// Bit-time tick counter: counts 0..baud_div-1, flags mid-bit sample and bit end.
// Cleared whenever the owning sequencer changes state.
module uart_bit_tick #(
   parameter int unsigned BAUD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [BAUD_W-1:0] baud_div,
   output logic              sample,
   output logic              bit_end
);

   localparam logic [BAUD_W-1:0] One = BAUD_W'(1);

   logic [BAUD_W-1:0] tick_q, tick_d;

   always_comb begin
      sample  = (tick_q == (baud_div >> 1));
      bit_end = (tick_q == (baud_div - One));
      tick_d  = tick_q + One;
      if (clear || bit_end) begin
         tick_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_d;
      end
   end

endmodule

// File: rtl/uart_rx_frame_seq.sv
// UART receive-frame sequencer: start/data/parity/stop decode with runtime frame format.
// Parity checking is built only when UART_RX_PARITY_CHK_EN is defined.
module uart_rx_frame_seq
   import uart_pkg::*;
#(
   parameter int unsigned MAX_DATA_BITS = 9,
   parameter int unsigned BAUD_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   input  logic [BAUD_W-1:0]        baud_div,
   input  logic [3:0]               data_bits,
   input  logic                     p_en,
   input  logic                     p_odd,
   input  logic                     stop2,
   output logic                     busy,
   output logic                     sample,
   output logic [3:0]               bit_idx,
   output logic [MAX_DATA_BITS-1:0] data,
   output logic                     done,
   output logic                     start_err,
   output logic                     frame_err,
   output logic                     parity_err
);

   rx_state_e state_q, state_d;

   logic [BAUD_W-1:0]        baud_q;
   logic [3:0]               db_q;
   logic                     p_en_q;
   logic                     stop2_q;
   logic [3:0]               bit_idx_q, bit_idx_d;
   logic [MAX_DATA_BITS-1:0] data_q, data_d;
   logic                     stop_err_q, stop_err_d;

   logic [BAUD_W-1:0] baud_clamp;
   logic [3:0]        db_clamp;
   logic              latch;
   logic              tick_clear;
   logic              tick_sample;
   logic              bit_end;
   logic              done_c;
   logic              serr_c;
   logic              ferr_c;

   always_comb begin
      db_clamp = data_bits;
      if (data_bits < 4'(MIN_DATA_BITS)) begin
         db_clamp = 4'(MIN_DATA_BITS);
      end else if (data_bits > 4'(MAX_DATA_BITS)) begin
         db_clamp = 4'(MAX_DATA_BITS);
      end
      baud_clamp = (baud_div < BAUD_W'(2)) ? BAUD_W'(2) : baud_div;
   end

   uart_bit_tick #(
      .BAUD_W (BAUD_W)
   ) u_bit_tick (
      .clk      (clk),
      .rst      (rst),
      .clear    (tick_clear),
      .baud_div (baud_q),
      .sample   (tick_sample),
      .bit_end  (bit_end)
   );

   // Tick restarts on every state entry and is held at zero while idle.
   assign tick_clear = (state_d != state_q) || (state_q == StIdle);

   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      stop_err_d = stop_err_q;
      latch      = 1'b0;
      done_c     = 1'b0;
      serr_c     = 1'b0;
      ferr_c     = 1'b0;

      case (state_q)
         StIdle: begin
            bit_idx_d = '0;
            if (!rx) begin
               state_d    = StStart;
               latch      = 1'b1;
               data_d     = '0;
               stop_err_d = 1'b0;
            end
         end

         StStart: begin
            if (tick_sample && rx) begin
               serr_c  = 1'b1;
               state_d = StIdle;
            end else if (bit_end) begin
               state_d   = StData;
               bit_idx_d = '0;
            end
         end

         StData: begin
            if (tick_sample) begin
               // Shift right and insert at the top of the active width: LSB-first, right-justified.
               data_d = data_q >> 1;
               for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                  if (i == 32'(db_q) - 32'd1) begin
                     data_d[i] = rx;
                  end
               end
            end
            if (bit_end) begin
               if (bit_idx_q == db_q - 4'd1) begin
                  state_d = p_en_q ? StParity : StStop1;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end

         StParity: begin
            if (bit_end) begin
               state_d = StStop1;
            end
         end

         StStop1: begin
            if (stop2_q) begin
               if (tick_sample && !rx) begin
                  stop_err_d = 1'b1;
               end
               if (bit_end) begin
                  state_d = StStop2;
               end
            end else if (tick_sample) begin
               // Leave at mid-stop so a back-to-back start edge is not missed.
               done_c  = 1'b1;
               ferr_c  = ~rx;
               state_d = StIdle;
            end
         end

         StStop2: begin
            if (tick_sample) begin
               done_c  = 1'b1;
               ferr_c  = stop_err_q | ~rx;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_idx_q  <= '0;
         data_q     <= '0;
         stop_err_q <= 1'b0;
         baud_q     <= BAUD_W'(2);
         db_q       <= 4'(MIN_DATA_BITS);
         p_en_q     <= 1'b0;
         stop2_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         data_q     <= data_d;
         stop_err_q <= stop_err_d;
         if (latch) begin
            baud_q  <= baud_clamp;
            db_q    <= db_clamp;
            p_en_q  <= p_en;
            stop2_q <= stop2;
         end
      end
   end

   assign busy      = (state_q != StIdle) && !rst;
   assign sample    = tick_sample && busy;
   assign bit_idx   = bit_idx_q;
   assign data      = data_q;
   assign done      = done_c && !rst;
   assign start_err = serr_c && !rst;
   assign frame_err = ferr_c && !rst;

`ifdef UART_RX_PARITY_CHK_EN
   logic par_q;
   logic p_odd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q   <= 1'b0;
         p_odd_q <= 1'b0;
      end else begin
         if (latch) begin
            p_odd_q <= p_odd;
         end
         if ((state_q == StParity) && tick_sample) begin
            par_q <= rx;
         end
      end
   end

   // Upper data bits are zero at done, so reducing the whole register is safe.
   assign parity_err = done && p_en_q && ((^data_q ^ par_q) != p_odd_q);
`else
   logic unused_p_odd;
   assign unused_p_odd = p_odd;
   assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_seq.sv
// Directed bench for uart_rx_frame_seq: frames driven bit by bit, outputs checked per step.
module tb_uart_rx_frame_seq;

`ifdef UART_RX_PARITY_CHK_EN
   localparam logic PCHK = 1'b1;
`else
   localparam logic PCHK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        rx;
   logic [15:0] baud_div;
   logic [3:0]  data_bits;
   logic        p_en;
   logic        p_odd;
   logic        stop2;
   logic        busy;
   logic        sample;
   logic [3:0]  bit_idx;
   logic [8:0]  data;
   logic        done;
   logic        start_err;
   logic        frame_err;
   logic        parity_err;

   int n_run;
   int n_fail;

   // Per-run observations.
   int         d_cnt, d_cyc, s_cnt, s_bad, idx_max, e_cnt, e_cyc, stray;
   logic [8:0] d_data, r_data;
   logic       d_ferr, d_perr, busy_after;
   logic       r_pulse0, r_busy0, r_pulse1, r_busy1;
   logic [3:0] r_idx;

   uart_rx_frame_seq dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .baud_div   (baud_div),
      .data_bits  (data_bits),
      .p_en       (p_en),
      .p_odd      (p_odd),
      .stop2      (stop2),
      .busy       (busy),
      .sample     (sample),
      .bit_idx    (bit_idx),
      .data       (data),
      .done       (done),
      .start_err  (start_err),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Iteration 0 drives pat[0]; pat[k] then occupies iterations k*unit+1 .. k*unit+unit.
   // Iteration i is the i-th cycle after the start-detection edge.
   task automatic run(input logic [15:0] pat, input int nbits, input int unit,
                      input int total, input int rst_at);
      d_cnt = 0; d_cyc = -1; d_data = '0; d_ferr = 1'b0; d_perr = 1'b0;
      s_cnt = 0; s_bad = 0; idx_max = 0; e_cnt = 0; e_cyc = -1; stray = 0;
      busy_after = 1'b1;
      r_pulse0 = 1'b1; r_busy0 = 1'b1; r_pulse1 = 1'b1; r_busy1 = 1'b1;
      r_data = '1; r_idx = '1;
      for (int i = 0; i < total; i++) begin
         @(posedge clk);
         #1;
         rst = (i == rst_at);
         if (i == 0) rx = pat[0];
         else if ((i - 1) / unit < nbits) rx = pat[(i - 1) / unit];
         else rx = 1'b1;
         #1;
         if (done) begin
            d_cnt++;
            if (d_cnt == 1) begin
               d_cyc = i; d_data = data; d_ferr = frame_err; d_perr = parity_err;
            end
         end
         if ((frame_err || parity_err) && !done) stray++;
         if (sample) begin
            s_cnt++;
            if ((i - 1) % unit != unit / 2) s_bad++;
         end
         if (busy && int'(bit_idx) > idx_max) idx_max = int'(bit_idx);
         if (start_err) begin
            e_cnt++;
            if (e_cnt == 1) e_cyc = i;
         end
         if (e_cnt > 0 && i == e_cyc + 1) busy_after = busy;
         if (i == rst_at) begin
            r_pulse0 = done | start_err | frame_err | parity_err | sample;
            r_busy0  = busy;
         end
         if (i == rst_at + 1) begin
            r_pulse1 = done | start_err | frame_err | parity_err | sample;
            r_busy1  = busy;
            r_data   = data;
            r_idx    = bit_idx;
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_run = 0; n_fail = 0;
      rst = 1'b1; rx = 1'b1;
      baud_div = 16'd16; data_bits = 4'd8; p_en = 1'b0; p_odd = 1'b0; stop2 = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy_during", 32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_bit_idx", 32'(bit_idx), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // 1: 8N1 0xA5, divisor 16
      run({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16, 200, -1);
      chk("t1_done_cnt", 32'(d_cnt), 32'd1);
      chk("t1_done_cyc", 32'(d_cyc), 32'd153);
      chk("t1_data", 32'(d_data), 32'h0A5);
      chk("t1_ferr", 32'(d_ferr), 32'd0);
      chk("t1_perr", 32'(d_perr), 32'd0);
      chk("t1_samples", 32'(s_cnt), 32'd10);
      chk("t1_sample_pos", 32'(s_bad), 32'd0);
      chk("t1_idx_max", 32'(idx_max), 32'd7);
      chk("t1_start_err", 32'(e_cnt), 32'd0);
      chk("t1_stray", 32'(stray), 32'd0);

      // 2: 4-cycle glitch rejected at the start-bit sample
      run(16'h0000, 1, 3, 40, -1);
      chk("t2_serr_cnt", 32'(e_cnt), 32'd1);
      chk("t2_serr_cyc", 32'(e_cyc), 32'd9);
      chk("t2_busy_after", 32'(busy_after), 32'd0);
      chk("t2_done_cnt", 32'(d_cnt), 32'd0);

      // 3: 7E1 0x41, correct even parity (0) then flipped
      data_bits = 4'd7; p_en = 1'b1; p_odd = 1'b0;
      run({6'b0, 1'b1, 1'b0, 7'h41, 1'b0}, 10, 16, 200, -1);
      chk("t3a_done_cnt", 32'(d_cnt), 32'd1);
      chk("t3a_done_cyc", 32'(d_cyc), 32'd153);
      chk("t3a_data", 32'(d_data), 32'h041);
      chk("t3a_perr", 32'(d_perr), 32'd0);
      run({6'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 10, 16, 200, -1);
      chk("t3b_done_cnt", 32'(d_cnt), 32'd1);
      chk("t3b_data", 32'(d_data), 32'h041);
      chk("t3b_perr", 32'(d_perr), 32'(PCHK));
      chk("t3b_stray", 32'(stray), 32'd0);

      // 4: 8N2 0x3C, first stop bit forced low
      data_bits = 4'd8; p_en = 1'b0; stop2 = 1'b1;
      run({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 16, 200, -1);
      chk("t4_done_cnt", 32'(d_cnt), 32'd1);
      chk("t4_done_cyc", 32'(d_cyc), 32'd169);
      chk("t4_ferr", 32'(d_ferr), 32'd1);
      chk("t4_data", 32'(d_data), 32'h03C);

      // 5: data_bits=3, baud_div=1 clamp to 5 bits, divisor 2
      stop2 = 1'b0; data_bits = 4'd3; baud_div = 16'd1;
      run({9'b0, 1'b1, 5'h15, 1'b0}, 7, 2, 30, -1);
      chk("t5_done_cnt", 32'(d_cnt), 32'd1);
      chk("t5_done_cyc", 32'(d_cyc), 32'd14);
      chk("t5_data", 32'(d_data), 32'h015);
      chk("t5_ferr", 32'(d_ferr), 32'd0);

      // 6: reset pulse mid-DATA, then a clean 8N1 0xFF
      data_bits = 4'd8; baud_div = 16'd16;
      run({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 16, 200, 50);
      chk("t6_rst_pulses", 32'(r_pulse0), 32'd0);
      chk("t6_rst_busy", 32'(r_busy0), 32'd0);
      chk("t6_post_pulses", 32'(r_pulse1), 32'd0);
      chk("t6_post_busy", 32'(r_busy1), 32'd0);
      chk("t6_post_data", 32'(r_data), 32'd0);
      chk("t6_post_idx", 32'(r_idx), 32'd0);
      chk("t6_no_done", 32'(d_cnt), 32'd0);
      run({6'b0, 1'b1, 8'hFF, 1'b0}, 10, 16, 200, -1);
      chk("t6b_done_cnt", 32'(d_cnt), 32'd1);
      chk("t6b_done_cyc", 32'(d_cyc), 32'd153);
      chk("t6b_data", 32'(d_data), 32'h0FF);
      chk("t6b_ferr", 32'(d_ferr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
